// File: rtl/imem_pkg.sv
// Shared constants and address helpers for the instruction-memory arbiter.
package imem_pkg;

    localparam int          DEPTH      = 65;
    localparam int          IDX_W      = 7;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0033;
    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

    // Byte address -> word index; the two byte-offset bits are ignored.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    // The full word address is compared, so aliases above DEPTH are rejected.
    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:2] < 30'(DEPTH);
    endfunction

endpackage

// File: rtl/imem_addr_chk.sv
// Converts a byte address into a memory word index plus an out-of-range flag.
module imem_addr_chk
    import imem_pkg::*;
(
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] idx,
    output logic             oor
);

    assign idx = word_idx(addr);
    assign oor = ~in_range(addr);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-ported instruction memory between the fetch port
// (priority, pipelined) and the loader port (one access outstanding, bounded wait).
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    input  logic             f_flush,
    output logic             f_gnt,
    output logic             f_stall,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic             f_err,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_ack,
    output logic [31:0]      l_rdata,
    output logic             l_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    logic [IDX_W-1:0] f_idx, l_idx;
    logic             f_oor, l_oor;
    logic             l_eligible, l_gnt;
    logic [3:0]       wait_cnt;
    logic             pf, pf_err;
    logic             pl, pl_err, pl_rd;

    imem_addr_chk u_f_chk (.addr(f_addr), .idx(f_idx), .oor(f_oor));
    imem_addr_chk u_l_chk (.addr(l_addr), .idx(l_idx), .oor(l_oor));

    assign l_eligible = l_req & ~pl;
    assign f_stall    = f_req & ~f_gnt;

    // Grant selection and memory drive; loader wins when starved, fetch idle or fetch flushed.
    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave one unassigned (no latch).
        l_gnt     = 1'b0;
        f_gnt     = 1'b0;
        if (rst) begin
            if (l_eligible && (wait_cnt == 4'(MAX_WAIT) || !f_req || f_flush)) begin
                l_gnt = 1'b1;
            end else if (f_req && !f_flush) begin
                f_gnt = 1'b1;
            end
        end
        mem_en    = (l_gnt & ~l_oor) | (f_gnt & ~f_oor);
        mem_we    = l_gnt & ~l_oor & l_we;
        mem_idx   = l_gnt ? l_idx : f_idx;
        mem_wdata = l_wdata;
    end

    // Responses leave the pending flags one cycle after the grant; a low rst silences them at once.
    always_comb begin
        f_rvalid = rst & pf & ~f_flush;
        f_err    = rst & pf_err;
        f_rdata  = '0;
        if (rst && pf) begin
            f_rdata = pf_err ? NOP_INSN : mem_rdata;
        end
        l_ack    = rst & pl;
        l_err    = rst & pl_err;
        l_rdata  = (rst && pl && pl_rd) ? mem_rdata : '0;
    end

    // Pending-response flags and the loader starvation counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            pf       <= 1'b0;
            pf_err   <= 1'b0;
            pl       <= 1'b0;
            pl_err   <= 1'b0;
            pl_rd    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            pf     <= f_gnt;
            pf_err <= f_gnt & f_oor;
            pl     <= l_gnt;
            pl_err <= l_gnt & l_oor;
            pl_rd  <= l_gnt & ~l_we & ~l_oor;
            if (!l_req || l_gnt) begin
                wait_cnt <= '0;
            end else if (l_eligible && wait_cnt != 4'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule
